regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single RegFile write port between two writeback requesters: A (main execute/writeback pipe) and B (multi-cycle unit, e.g. load/mul).
- Holds a pending-destination scoreboard so decode can stall on RAW hazards, and blocks a new destination allocation while an earlier write to the same register is still outstanding (WAW).
- Sits between the writeback stage and RegFile; drives RegWriteData/RegWriteIndex/RegWEn directly.

Parameters:
- XLEN, 32, data width.
- NREGS, 32, architectural register count; index width = $clog2(NREGS).
- STARVE_MAX, 4, number of consecutive cycles B may wait with b_val=1 before it takes priority over A.

Ports:
- clk  in  1  clock, all state on posedge.
- reset  in  1  synchronous, active-high.
- a_val  in  1  requester A write valid.
- a_rdy  out  1  requester A granted.
- a_idx  in  5  A destination register.
- a_data  in  XLEN  A write data.
- b_val  in  1  requester B write valid.
- b_rdy  out  1  requester B granted.
- b_idx  in  5  B destination register.
- b_data  in  XLEN  B write data.
- alloc_val  in  1  decode marks a destination pending.
- alloc_idx  in  5  register being allocated.
- alloc_rdy  out  1  allocation accepted.
- rs1_idx  in  5  decode source 1 lookup.
- rs2_idx  in  5  decode source 2 lookup.
- rs1_busy  out  1  rs1 has a pending write.
- rs2_busy  out  1  rs2 has a pending write.
- RegWEn  out  1  to RegFile write enable.
- RegWriteIndex  out  5  to RegFile write index.
- RegWriteData  out  XLEN  to RegFile write data.

Behaviour:
- Reset: synchronous and active-high.
  - Clears RegWEn, RegWriteIndex, RegWriteData, all pending bits and the starve counter.
  - Any in-flight registered write is dropped: RegWEn=0 on the cycle after reset is asserted.
- Arbitration is combinational from the valids. At most one of a_rdy/b_rdy is 1 per cycle.
  - Default priority goes to A: a_rdy=a_val; b_rdy=b_val & ~a_val.
  - If starve_cnt==STARVE_MAX and b_val=1, B wins: b_rdy=1, a_rdy=0.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) when b_val=1 and B is not granted.
  - Resets to 0 when B is granted or when b_val=0.
- Handshake: a transfer occurs when val&rdy. Requesters hold idx/data stable while val=1 and rdy=0.
- Write stage: one registered stage, so latency is 1 cycle from transfer to RegWEn=1.
  - On the cycle after a transfer: RegWEn=1, RegWriteIndex=idx, RegWriteData=data.
  - If there is no transfer, RegWEn=0 and index/data hold their previous values.
- Transfer with idx=0 completes the handshake, but RegWEn stays 0.
- Scoreboard (pending[NREGS-1:0]):
  - Set on alloc_val&alloc_rdy.
  - Cleared on the posedge where RegWEn=1 for that index.
  - alloc_rdy = ~pending[alloc_idx] | (alloc_idx==0). Allocating x0 is accepted but sets nothing.
  - Set and clear of the same index on the same edge: set wins.
- Busy outputs are combinational: rsN_busy = pending[rsN_idx] & (rsN_idx!=0).
  - During the RegWEn cycle for that index, rsN_busy is still 1, because RegFile has not yet captured the data.
- A transfer whose index is not pending is still written; the scoreboard is unaffected.
- Simultaneous a_val and b_val to the same index: the grant order defines the write order; the loser writes in a later cycle.

Optional Feature:
- Macro: REGFILE_WB_FWD_EN.
- Enabled:
  - Adds outputs rs1_fwd_val, rs2_fwd_val (1) and rs1_fwd_data, rs2_fwd_data (XLEN).
  - When RegWEn=1 and RegWriteIndex==rsN_idx!=0: rsN_fwd_val=1, rsN_fwd_data=RegWriteData, and rsN_busy is forced to 0 that cycle.
- Disabled: these ports do not exist, and busy behaves as described above.

Decomposition:
- Shared package / header `RegNames.vh`: REG_IDX_W=5, REG_ZERO=0, XLEN default, requester encoding constants (WB_REQ_A=0, WB_REQ_B=1).
- One natural sub-module, wb_scoreboard: the pending vector, the alloc/clear logic, the busy lookups and the forward compare.
- The arbiter and write register stay in the top module.

Test Plan:
- Reset, then a_val=1, a_idx=5, a_data=0xDEADBEEF -> a_rdy=1; the next cycle RegWEn=1, RegWriteIndex=5, RegWriteData=0xDEADBEEF.
- a_val and b_val held at 1 continuously with STARVE_MAX=4 -> A is granted 4 cycles, B on the 5th, then A again.
- alloc_idx=7 accepted, then rs1_idx=7 -> rs1_busy=1. A second alloc of 7 gives alloc_rdy=0. b_idx=7 write -> busy drops after the RegWEn edge, and alloc of 7 is accepted again.
- a_idx=0, a_data=0x1234 -> handshake completes and RegWEn stays 0. Alloc of 0 -> alloc_rdy=1 and rs2_idx=0 gives busy=0.
- Transfer accepted, then reset asserted the next cycle -> RegWEn=0 and all pending bits clear.
- With REGFILE_WB_FWD_EN: pending x9, write x9=0xCAFE with rs1_idx=9 -> during the RegWEn cycle rs1_busy=0, rs1_fwd_val=1, rs1_fwd_data=0xCAFE.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the RegFile writeback arbiter and its scoreboard.
// Optional forwarding outputs are enabled by defining REGFILE_WB_FWD_EN.
package regfile_wb_arbiter_pkg;

    localparam int REG_IDX_W    = 5;
    localparam int REG_ZERO     = 0;
    localparam int XLEN_DEFAULT = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic {
        WB_REQ_A = 1'b0,
        WB_REQ_B = 1'b1
    } wb_req_e;

    function automatic logic is_zero_reg(input reg_idx_t idx);
        return idx == reg_idx_t'(REG_ZERO);
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// Pending-destination scoreboard: allocation, clear on RegFile write, busy lookups.
// With REGFILE_WB_FWD_EN, the write in flight is forwarded and masks busy.
module wb_scoreboard
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int XLEN  = XLEN_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alloc_val_i,
    input  logic [REG_IDX_W-1:0] alloc_idx_i,
    output logic                 alloc_rdy_o,
    input  logic [REG_IDX_W-1:0] rs1_idx_i,
    input  logic [REG_IDX_W-1:0] rs2_idx_i,
    output logic                 rs1_busy_o,
    output logic                 rs2_busy_o,
    input  logic                 wr_en_i,
    input  logic [REG_IDX_W-1:0] wr_idx_i,
    input  logic [XLEN-1:0]      wr_data_i
`ifdef REGFILE_WB_FWD_EN
    ,
    output logic                 rs1_fwd_val_o,
    output logic                 rs2_fwd_val_o,
    output logic [XLEN-1:0]      rs1_fwd_data_o,
    output logic [XLEN-1:0]      rs2_fwd_data_o
`endif
);

    logic [NREGS-1:0] pending_q, pending_d;
    logic             rs1_pend, rs2_pend;

    assign alloc_rdy_o = !pending_q[alloc_idx_i] || is_zero_reg(alloc_idx_i);
    assign rs1_pend    = pending_q[rs1_idx_i] && !is_zero_reg(rs1_idx_i);
    assign rs2_pend    = pending_q[rs2_idx_i] && !is_zero_reg(rs2_idx_i);

    // NOTE: combinational blocks assign a default first so no path leaves a latch.
    always_comb begin
        pending_d = pending_q;
        if (wr_en_i)
            pending_d[wr_idx_i] = 1'b0;
        // Applied after the clear so a same-edge allocation of the written index wins.
        if (alloc_val_i && alloc_rdy_o && !is_zero_reg(alloc_idx_i))
            pending_d[alloc_idx_i] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) pending_q <= '0;
        else       pending_q <= pending_d;
    end

`ifdef REGFILE_WB_FWD_EN
    assign rs1_fwd_val_o  = wr_en_i && (wr_idx_i == rs1_idx_i) && !is_zero_reg(rs1_idx_i);
    assign rs2_fwd_val_o  = wr_en_i && (wr_idx_i == rs2_idx_i) && !is_zero_reg(rs2_idx_i);
    assign rs1_fwd_data_o = wr_data_i;
    assign rs2_fwd_data_o = wr_data_i;
    assign rs1_busy_o     = rs1_pend && !rs1_fwd_val_o;
    assign rs2_busy_o     = rs2_pend && !rs2_fwd_val_o;
`else
    // The registered write is not yet in RegFile, so busy holds through the RegWEn cycle.
    assign rs1_busy_o = rs1_pend;
    assign rs2_busy_o = rs2_pend;
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-requester arbiter for the single RegFile write port, with starvation guard and one write register.
// Define REGFILE_WB_FWD_EN to add rsN_fwd_val/rsN_fwd_data forwarding outputs.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int NREGS      = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 a_val,
    output logic                 a_rdy,
    input  logic [REG_IDX_W-1:0] a_idx,
    input  logic [XLEN-1:0]      a_data,
    input  logic                 b_val,
    output logic                 b_rdy,
    input  logic [REG_IDX_W-1:0] b_idx,
    input  logic [XLEN-1:0]      b_data,
    input  logic                 alloc_val,
    input  logic [REG_IDX_W-1:0] alloc_idx,
    output logic                 alloc_rdy,
    input  logic [REG_IDX_W-1:0] rs1_idx,
    input  logic [REG_IDX_W-1:0] rs2_idx,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic                 RegWEn,
    output logic [REG_IDX_W-1:0] RegWriteIndex,
    output logic [XLEN-1:0]      RegWriteData
`ifdef REGFILE_WB_FWD_EN
    ,
    output logic                 rs1_fwd_val,
    output logic                 rs2_fwd_val,
    output logic [XLEN-1:0]      rs1_fwd_data,
    output logic [XLEN-1:0]      rs2_fwd_data
`endif
);

    localparam int                CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0]     starve_q, starve_d;
    logic                 b_prio;
    logic                 xfer;
    wb_req_e              sel;
    logic [REG_IDX_W-1:0] sel_idx;
    logic [XLEN-1:0]      sel_data;

    logic                 wen_q, wen_d;
    logic [REG_IDX_W-1:0] widx_q, widx_d;
    logic [XLEN-1:0]      wdata_q, wdata_d;

    always_comb begin
        b_prio = b_val && (starve_q == CNT_MAX);
        a_rdy  = a_val && !b_prio;
        b_rdy  = b_val && (b_prio || !a_val);
        xfer   = a_rdy || b_rdy;
        sel    = b_rdy ? WB_REQ_B : WB_REQ_A;

        sel_idx  = (sel == WB_REQ_B) ? b_idx  : a_idx;
        sel_data = (sel == WB_REQ_B) ? b_data : a_data;

        starve_d = starve_q;
        if (!b_val || b_rdy)
            starve_d = '0;
        else if (starve_q != CNT_MAX)
            starve_d = starve_q + 1'b1;

        // A handshake to x0 completes but never reaches RegFile.
        wen_d   = xfer && !is_zero_reg(sel_idx);
        widx_d  = xfer ? sel_idx  : widx_q;
        wdata_d = xfer ? sel_data : wdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
            wen_q    <= 1'b0;
            widx_q   <= '0;
            wdata_q  <= '0;
        end else begin
            starve_q <= starve_d;
            wen_q    <= wen_d;
            widx_q   <= widx_d;
            wdata_q  <= wdata_d;
        end
    end

    assign RegWEn        = wen_q;
    assign RegWriteIndex = widx_q;
    assign RegWriteData  = wdata_q;

    wb_scoreboard #(
        .NREGS (NREGS),
        .XLEN  (XLEN)
    ) u_scoreboard (
        .clk            (clk),
        .reset          (reset),
        .alloc_val_i    (alloc_val),
        .alloc_idx_i    (alloc_idx),
        .alloc_rdy_o    (alloc_rdy),
        .rs1_idx_i      (rs1_idx),
        .rs2_idx_i      (rs2_idx),
        .rs1_busy_o     (rs1_busy),
        .rs2_busy_o     (rs2_busy),
        .wr_en_i        (wen_q),
        .wr_idx_i       (widx_q),
        .wr_data_i      (wdata_q)
`ifdef REGFILE_WB_FWD_EN
        ,
        .rs1_fwd_val_o  (rs1_fwd_val),
        .rs2_fwd_val_o  (rs2_fwd_val),
        .rs1_fwd_data_o (rs1_fwd_data),
        .rs2_fwd_data_o (rs2_fwd_data)
`endif
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios then randomized traffic
// against a behavioural model of grants, the write stage and the pending set.
module tb_regfile_wb_arbiter;

    localparam int XLEN       = 32;
    localparam int STARVE_MAX = 4;

    logic            clk;
    logic            reset;
    logic            a_val, a_rdy;
    logic [4:0]      a_idx;
    logic [XLEN-1:0] a_data;
    logic            b_val, b_rdy;
    logic [4:0]      b_idx;
    logic [XLEN-1:0] b_data;
    logic            alloc_val, alloc_rdy;
    logic [4:0]      alloc_idx;
    logic [4:0]      rs1_idx, rs2_idx;
    logic            rs1_busy, rs2_busy;
    logic            RegWEn;
    logic [4:0]      RegWriteIndex;
    logic [XLEN-1:0] RegWriteData;
`ifdef REGFILE_WB_FWD_EN
    logic            rs1_fwd_val, rs2_fwd_val;
    logic [XLEN-1:0] rs1_fwd_data, rs2_fwd_data;
`endif

    regfile_wb_arbiter #(
        .XLEN       (XLEN),
        .NREGS      (32),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .a_val         (a_val),
        .a_rdy         (a_rdy),
        .a_idx         (a_idx),
        .a_data        (a_data),
        .b_val         (b_val),
        .b_rdy         (b_rdy),
        .b_idx         (b_idx),
        .b_data        (b_data),
        .alloc_val     (alloc_val),
        .alloc_idx     (alloc_idx),
        .alloc_rdy     (alloc_rdy),
        .rs1_idx       (rs1_idx),
        .rs2_idx       (rs2_idx),
        .rs1_busy      (rs1_busy),
        .rs2_busy      (rs2_busy),
        .RegWEn        (RegWEn),
        .RegWriteIndex (RegWriteIndex),
        .RegWriteData  (RegWriteData)
`ifdef REGFILE_WB_FWD_EN
        ,
        .rs1_fwd_val   (rs1_fwd_val),
        .rs2_fwd_val   (rs2_fwd_val),
        .rs1_fwd_data  (rs1_fwd_data),
        .rs2_fwd_data  (rs2_fwd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0]     m_pend;
    int              m_wait;
    logic            m_wen;
    logic [4:0]      m_widx;
    logic [XLEN-1:0] m_wdata;

    // Combinational outputs as sampled in the most recent cycle
    logic o_a_rdy, o_b_rdy, o_alloc_rdy, o_rs1_busy, o_rs2_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("assertion on %s", tag);
        end
    endtask

    task automatic idle();
        a_val = 0; a_idx = 0; a_data = 0;
        b_val = 0; b_idx = 0; b_data = 0;
        alloc_val = 0; alloc_idx = 0;
        rs1_idx = 0; rs2_idx = 0;
    endtask

    // One clock: check combinational outputs, advance the model, check the write stage.
    task automatic cycle(input bit chk_comb);
        bit              ea, eb, eal, e1, e2, f1, f2;
        logic [4:0]      w_idx;
        logic [XLEN-1:0] w_data;
        #1;
        eb  = b_val && (m_wait >= STARVE_MAX || !a_val);
        ea  = a_val && !eb;
        eal = (alloc_idx == 0) || !m_pend[alloc_idx];
        f1  = m_wen && m_widx == rs1_idx && rs1_idx != 0;
        f2  = m_wen && m_widx == rs2_idx && rs2_idx != 0;
        e1  = m_pend[rs1_idx] && rs1_idx != 0;
        e2  = m_pend[rs2_idx] && rs2_idx != 0;
`ifdef REGFILE_WB_FWD_EN
        e1 = e1 && !f1;
        e2 = e2 && !f2;
`endif
        o_a_rdy = a_rdy; o_b_rdy = b_rdy; o_alloc_rdy = alloc_rdy;
        o_rs1_busy = rs1_busy; o_rs2_busy = rs2_busy;
        if (chk_comb) begin
            check("a_rdy", 32'(a_rdy), 32'(ea));
            check("b_rdy", 32'(b_rdy), 32'(eb));
            check("alloc_rdy", 32'(alloc_rdy), 32'(eal));
            check("rs1_busy", 32'(rs1_busy), 32'(e1));
            check("rs2_busy", 32'(rs2_busy), 32'(e2));
`ifdef REGFILE_WB_FWD_EN
            check("rs1_fwd_val", 32'(rs1_fwd_val), 32'(f1));
            check("rs2_fwd_val", 32'(rs2_fwd_val), 32'(f2));
            if (f1) check("rs1_fwd_data", rs1_fwd_data, m_wdata);
            if (f2) check("rs2_fwd_data", rs2_fwd_data, m_wdata);
`endif
        end
        if (reset) begin
            m_pend = '0; m_wait = 0; m_wen = 0; m_widx = 0; m_wdata = 0;
        end else begin
            if (m_wen) m_pend[m_widx] = 1'b0;
            if (alloc_val && eal && alloc_idx != 0) m_pend[alloc_idx] = 1'b1;
            if (!b_val || eb) m_wait = 0;
            else if (m_wait < STARVE_MAX) m_wait++;
            if (ea || eb) begin
                w_idx   = ea ? a_idx : b_idx;
                w_data  = ea ? a_data : b_data;
                m_wen   = (w_idx != 0);
                m_widx  = w_idx;
                m_wdata = w_data;
            end else begin
                m_wen = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check("RegWEn", 32'(RegWEn), 32'(m_wen));
        check("RegWriteIndex", 32'(RegWriteIndex), 32'(m_widx));
        check("RegWriteData", RegWriteData, m_wdata);
        @(negedge clk);
    endtask

    initial begin
        m_pend = '0; m_wait = 0; m_wen = 0; m_widx = 0; m_wdata = 0;
        idle();
        reset = 1'b1;
        @(negedge clk);
        cycle(0);
        cycle(1);
        reset = 1'b0;
        check("rst_wen", 32'(RegWEn), 32'd0);

        // Single A write lands one cycle later
        a_val = 1; a_idx = 5; a_data = 32'hDEADBEEF;
        cycle(1);
        check("t1_a_rdy", 32'(o_a_rdy), 32'd1);
        check("t1_wen", 32'(RegWEn), 32'd1);
        check("t1_widx", 32'(RegWriteIndex), 32'd5);
        check("t1_wdata", RegWriteData, 32'hDEADBEEF);
        idle();
        cycle(1);

        // Both requesters held: A four times, then B, then A
        b_val = 1; b_idx = 2; b_data = 32'hB0B0_0002;
        for (int i = 0; i < 6; i++) begin
            a_val = 1; a_idx = 1; a_data = 32'hA000_0000 + 32'(i);
            cycle(1);
            check("starve_a_rdy", 32'(o_a_rdy), (i == 4) ? 32'd0 : 32'd1);
            check("starve_b_rdy", 32'(o_b_rdy), (i == 4) ? 32'd1 : 32'd0);
            if (i == 4) check("starve_b_data", RegWriteData, 32'hB0B0_0002);
        end
        idle();
        cycle(1);

        // Scoreboard: allocate x7, RAW busy, WAW block, clear by B write
        alloc_val = 1; alloc_idx = 7;
        cycle(1);
        check("alloc7_rdy", 32'(o_alloc_rdy), 32'd1);
        alloc_val = 0; rs1_idx = 7;
        cycle(1);
        check("rs1_busy7", 32'(o_rs1_busy), 32'd1);
        alloc_val = 1;
        cycle(1);
        check("alloc7_waw", 32'(o_alloc_rdy), 32'd0);
        alloc_val = 0; b_val = 1; b_idx = 7; b_data = 32'h0000_0077;
        cycle(1);
        b_val = 0;
        cycle(1);
`ifndef REGFILE_WB_FWD_EN
        check("busy7_during_wen", 32'(o_rs1_busy), 32'd1);
`endif
        cycle(1);
        check("busy7_cleared", 32'(o_rs1_busy), 32'd0);
        alloc_val = 1;
        cycle(1);
        check("alloc7_again", 32'(o_alloc_rdy), 32'd1);
        idle();

        // Unallocated write of x8 and allocation of x8 on the same edge: set wins
        a_val = 1; a_idx = 8; a_data = 32'h8888;
        cycle(1);
        idle(); alloc_val = 1; alloc_idx = 8;
        cycle(1);
        idle(); rs2_idx = 8;
        cycle(1);
        check("set_wins_busy8", 32'(o_rs2_busy), 32'd1);

        // x0 write and x0 allocation
        idle(); a_val = 1; a_idx = 0; a_data = 32'h1234;
        cycle(1);
        check("x0_a_rdy", 32'(o_a_rdy), 32'd1);
        check("x0_wen", 32'(RegWEn), 32'd0);
        idle(); alloc_val = 1; alloc_idx = 0; rs2_idx = 0;
        cycle(1);
        check("x0_alloc_rdy", 32'(o_alloc_rdy), 32'd1);
        check("x0_busy", 32'(o_rs2_busy), 32'd0);
        idle();

        // Reset right after a transfer drops the write and the pending set
        a_val = 1; a_idx = 3; a_data = 32'h3333;
        cycle(1);
        idle(); reset = 1;
        cycle(1);
        check("rst_drop_wen", 32'(RegWEn), 32'd0);
        reset = 0; rs1_idx = 7; rs2_idx = 8;
        cycle(1);
        check("rst_busy7", 32'(o_rs1_busy), 32'd0);
        check("rst_busy8", 32'(o_rs2_busy), 32'd0);
        idle();

`ifdef REGFILE_WB_FWD_EN
        alloc_val = 1; alloc_idx = 9;
        cycle(1);
        idle(); a_val = 1; a_idx = 9; a_data = 32'hCAFE; rs1_idx = 9;
        cycle(1);
        a_val = 0;
        #1;
        check("fwd_busy", 32'(rs1_busy), 32'd0);
        check("fwd_val", 32'(rs1_fwd_val), 32'd1);
        check("fwd_data", rs1_fwd_data, 32'hCAFE);
        cycle(1);
        idle();
`endif

        // Randomized traffic; requesters hold idx/data until granted
        for (int n = 0; n < 500; n++) begin
            if (!(a_val && !o_a_rdy)) begin
                a_val  = ($urandom_range(0, 2) != 0);
                a_idx  = 5'($urandom_range(0, 7));
                a_data = $urandom;
            end
            if (!(b_val && !o_b_rdy)) begin
                b_val  = ($urandom_range(0, 2) != 0);
                b_idx  = 5'($urandom_range(0, 7));
                b_data = $urandom;
            end
            alloc_val = ($urandom_range(0, 1) != 0);
            alloc_idx = 5'($urandom_range(0, 7));
            rs1_idx   = 5'($urandom_range(0, 7));
            rs2_idx   = 5'($urandom_range(0, 7));
            reset     = ($urandom_range(0, 79) == 0);
            cycle(1);
            if (reset) begin
                o_a_rdy = 1; o_b_rdy = 1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
